// File: rtl/id_pipe.sv
// MIPS instruction-decode stage: register file, operand bypass,
// immediate extension and a stallable/flushable pipeline register.
module id_pipe #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            InValid,
  input  logic [31:0]     Ins,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            WEn,
  input  logic [AW-1:0]   Wadr,
  input  logic [XLEN-1:0] Wdata,
  output logic            OutValid,
  output logic [XLEN-1:0] Rdata1,
  output logic [XLEN-1:0] Rdata2,
  output logic [XLEN-1:0] Ed,
  output logic [5:0]      Opcode,
  output logic [5:0]      Funct,
  output logic [AW-1:0]   Dadr,
  output logic            DWEn
);

  logic [XLEN-1:0] rf_q [NREG];

  logic            vld_q;
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic [XLEN-1:0] rd2_q, rd2_d;
  logic [XLEN-1:0] ed_q, ed_d;
  logic [5:0]      op_q, fn_q;
  logic [AW-1:0]   dadr_q, dadr_d;
  logic            dwen_q, dwen_d;
  logic [AW-1:0]   rs_q, rt_q;

  logic [5:0]      op, fn;
  logic [AW-1:0]   rs, rt;
  logic [15:0]     imm;
  logic            wr_en;
  logic            is_zext, is_lui;
  logic            dwen_raw;

  assign op  = Ins[31:26];
  assign fn  = Ins[5:0];
  assign rs  = Ins[21 +: AW];
  assign rt  = Ins[16 +: AW];
  assign imm = Ins[15:0];

  // A write to r0 is dropped entirely, so it must never bypass either.
  assign wr_en = WEn && !((ZERO_REG != 0) && (Wadr == '0));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[Wadr] <= Wdata;
    end
  end

  always_comb begin
    rd1_d = rf_q[rs];
    rd2_d = rf_q[rt];
    if (wr_en && (Wadr == rs)) rd1_d = Wdata;
    if (wr_en && (Wadr == rt)) rd2_d = Wdata;
  end

  always_comb begin
    dadr_d = rt;
    unique case (1'b1)
      (op == 6'h00): dadr_d = Ins[11 +: AW];
      (op == 6'h03): dadr_d = {AW{1'b1}};
      default:       dadr_d = rt;
    endcase
  end

  always_comb begin
    dwen_raw = 1'b0;
    unique case (1'b1)
      (op == 6'h00):                   dwen_raw = (fn != 6'h08);
      (op == 6'h03):                   dwen_raw = 1'b1;
      (op >= 6'h08 && op <= 6'h0F):    dwen_raw = 1'b1;
      (op >= 6'h20 && op <= 6'h25):    dwen_raw = 1'b1;
      default:                         dwen_raw = 1'b0;
    endcase
    dwen_d = dwen_raw && InValid
          && !((ZERO_REG != 0) && (dadr_d == '0));
  end

  assign is_zext = (op >= 6'h0C) && (op <= 6'h0E);
  assign is_lui  = (op == 6'h0F);

  always_comb begin
    ed_d = {{(XLEN-16){imm[15]}}, imm};
    unique case (1'b1)
      is_zext: ed_d = XLEN'(imm);
      is_lui:  ed_d = XLEN'({imm, 16'h0000});
      default: ed_d = {{(XLEN-16){imm[15]}}, imm};
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q  <= 1'b0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      ed_q   <= '0;
      op_q   <= '0;
      fn_q   <= '0;
      dadr_q <= '0;
      dwen_q <= 1'b0;
      rs_q   <= '0;
      rt_q   <= '0;
    end else if (Flush) begin
      vld_q  <= 1'b0;
      dwen_q <= 1'b0;
    end else if (Stall) begin
      // Held operands track write-back so they are fresh on release.
      if (vld_q && wr_en && (Wadr == rs_q)) rd1_q <= Wdata;
      if (vld_q && wr_en && (Wadr == rt_q)) rd2_q <= Wdata;
    end else begin
      vld_q  <= InValid;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      ed_q   <= ed_d;
      op_q   <= op;
      fn_q   <= fn;
      dadr_q <= dadr_d;
      dwen_q <= dwen_d;
      rs_q   <= rs;
      rt_q   <= rt;
    end
  end

  assign OutValid = vld_q;
  assign Rdata1   = rd1_q;
  assign Rdata2   = rd2_q;
  assign Ed       = ed_q;
  assign Opcode   = op_q;
  assign Funct    = fn_q;
  assign Dadr     = dadr_q;
  assign DWEn     = dwen_q;

endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: reference model predicts each cycle's
// registered outputs, a negedge monitor pops and compares.
module tb_id_pipe;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            InValid = 1'b0;
  logic [31:0]     Ins = '0;
  logic            Stall = 1'b0;
  logic            Flush = 1'b0;
  logic            WEn = 1'b0;
  logic [AW-1:0]   Wadr = '0;
  logic [XLEN-1:0] Wdata = '0;
  logic            OutValid;
  logic [XLEN-1:0] Rdata1, Rdata2, Ed;
  logic [5:0]      Opcode, Funct;
  logic [AW-1:0]   Dadr;
  logic            DWEn;

  id_pipe #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST), .InValid(InValid), .Ins(Ins),
    .Stall(Stall), .Flush(Flush), .WEn(WEn), .Wadr(Wadr),
    .Wdata(Wdata), .OutValid(OutValid), .Rdata1(Rdata1),
    .Rdata2(Rdata2), .Ed(Ed), .Opcode(Opcode), .Funct(Funct),
    .Dadr(Dadr), .DWEn(DWEn)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        v;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] ed;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  da;
    logic        we;
  } out_t;

  out_t        exp_q[$];
  out_t        m_out;
  logic [31:0] m_rf [NREG];
  logic [4:0]  m_rs, m_rt;
  int          checks = 0;
  int          errors = 0;

  logic [5:0] ops [18] = '{6'h00, 6'h00, 6'h03, 6'h02, 6'h04, 6'h08,
                           6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                           6'h20, 6'h23, 6'h25, 6'h26, 6'h2B, 6'h3F};

  function automatic out_t cur();
    return {OutValid, Rdata1, Rdata2, Ed, Opcode, Funct, Dadr, DWEn};
  endfunction

  task automatic cmp(input string tag, input out_t a, input out_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got v=%b r1=%h r2=%h ed=%h op=%h fn=%h da=%0d we=%b want v=%b r1=%h r2=%h ed=%h op=%h fn=%h da=%0d we=%b",
               tag, a.v, a.r1, a.r2, a.ed, a.op, a.fn, a.da, a.we,
               e.v, e.r1, e.r2, e.ed, e.op, e.fn, e.da, e.we);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) cmp("out", cur(), exp_q.pop_front());
  end

  function automatic logic [31:0] r_ins(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic out_t decode(input logic iv, input logic [31:0] ins,
    input logic wr, input logic [4:0] wa, input logic [31:0] wd);
    out_t        n;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    op  = ins[31:26];
    fn  = ins[5:0];
    rs  = ins[25:21];
    rt  = ins[20:16];
    imm = ins[15:0];
    n.v  = iv;
    n.op = op;
    n.fn = fn;
    n.r1 = (wr && wa == rs) ? wd : m_rf[rs];
    n.r2 = (wr && wa == rt) ? wd : m_rf[rt];
    if (op == 6'h00)      n.da = ins[15:11];
    else if (op == 6'h03) n.da = 5'd31;
    else                  n.da = rt;
    if (op == 6'h00)                     n.we = (fn != 6'h08);
    else if (op == 6'h03)                n.we = 1'b1;
    else if (op inside {[6'h08:6'h0F]})  n.we = 1'b1;
    else if (op inside {[6'h20:6'h25]})  n.we = 1'b1;
    else                                 n.we = 1'b0;
    if (!iv || n.da == 5'd0) n.we = 1'b0;
    if (op inside {[6'h0C:6'h0E]}) n.ed = {16'h0000, imm};
    else if (op == 6'h0F)          n.ed = {imm, 16'h0000};
    else                           n.ed = {{16{imm[15]}}, imm};
    return n;
  endfunction

  task automatic step(input logic iv, input logic [31:0] ins,
    input logic st, input logic fl, input logic we,
    input logic [4:0] wa, input logic [31:0] wd);
    out_t n;
    logic wr;
    InValid = iv; Ins = ins; Stall = st; Flush = fl;
    WEn = we; Wadr = wa; Wdata = wd;
    wr = we && (wa != 5'd0);
    n = m_out;
    if (fl) begin
      n.v  = 1'b0;
      n.we = 1'b0;
    end else if (st) begin
      if (m_out.v && wr && m_rs == wa) n.r1 = wd;
      if (m_out.v && wr && m_rt == wa) n.r2 = wd;
    end else begin
      n = decode(iv, ins, wr, wa, wd);
      m_rs = ins[25:21];
      m_rt = ins[20:16];
    end
    if (wr) m_rf[wa] = wd;
    m_out = n;
    @(posedge CLK);
    exp_q.push_back(n);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    m_out = '0;
    m_rs  = '0;
    m_rt  = '0;
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  wa;
    logic [5:0]  op;
    model_clear();
    RST = 1'b1;
    @(posedge CLK);
    exp_q.push_back('0);
    #1;
    RST = 1'b0;

    step(0, 32'h0, 0, 0, 1, 5'd5, 32'h1234);
    step(1, r_ins(6'h00, 5'd5, 5'd5, 5'd3, 6'h20), 0, 0, 0, 0, 0);
    step(1, i_ins(6'h08, 5'd7, 5'd2, 16'h8000), 0, 0, 1, 5'd7, 32'hCAFE);
    step(0, 32'h0, 0, 0, 1, 5'd0, 32'hFFFF);
    step(1, r_ins(6'h00, 5'd0, 5'd0, 5'd4, 6'h20), 0, 0, 0, 0, 0);
    step(1, i_ins(6'h0D, 5'd1, 5'd2, 16'h8000), 0, 0, 0, 0, 0);
    step(1, i_ins(6'h0F, 5'd0, 5'd3, 16'h1234), 0, 0, 0, 0, 0);
    step(1, {6'h03, 26'h10}, 0, 0, 0, 0, 0);
    step(1, r_ins(6'h00, 5'd31, 5'd0, 5'd0, 6'h08), 0, 0, 0, 0, 0);

    step(1, r_ins(6'h00, 5'd9, 5'd9, 5'd1, 6'h20), 0, 0, 0, 0, 0);
    step(1, r_ins(6'h00, 5'd2, 5'd3, 5'd6, 6'h21), 1, 0, 1, 5'd9, 32'h55);
    step(1, r_ins(6'h00, 5'd2, 5'd3, 5'd6, 6'h21), 1, 0, 0, 0, 0);
    step(1, r_ins(6'h00, 5'd9, 5'd7, 5'd6, 6'h21), 0, 0, 0, 0, 0);
    step(1, i_ins(6'h23, 5'd5, 5'd8, 16'h0004), 1, 1, 0, 0, 0);
    step(1, i_ins(6'h23, 5'd5, 5'd8, 16'h0004), 1, 0, 0, 0, 0);

    step(1, r_ins(6'h00, 5'd5, 5'd9, 5'd3, 6'h20), 0, 0, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0, 0);
    @(negedge CLK);
    #2;
    RST = 1'b1; WEn = 1'b1; Wadr = 5'd1; Wdata = 32'hDEAD;
    model_clear();
    #1;
    cmp("async_rst", cur(), '0);
    @(posedge CLK);
    exp_q.push_back('0);
    #1;
    RST = 1'b0; WEn = 1'b0; Stall = 1'b0;
    for (int i = 1; i < NREG; i++)
      step(1, r_ins(6'h00, 5'(i), 5'(i), 5'd1, 6'h20), 0, 0, 0, 0, 0);

    for (int k = 0; k < 400; k++) begin
      op = ops[$urandom_range(17)];
      ins = $urandom;
      ins[31:26] = op;
      if ($urandom_range(3) == 0) ins[5:0] = 6'h08;
      wa = 5'($urandom);
      if ($urandom_range(4) == 0) wa = ins[25:21];
      if ($urandom_range(4) == 0) wa = ins[20:16];
      step(($urandom_range(99) < 85), ins,
           ($urandom_range(99) < 20), ($urandom_range(99) < 8),
           $urandom_range(1) == 1, wa, $urandom);
    end
    step(0, 32'h0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath/register width in bits (>= 32).
REQ-002 Parameter NREG, default 32, register count (power of two, 2..32); AW = log2(NREG) address bits.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes.
REQ-004 CLK  in  1  clock; all state changes on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 InValid  in  1  Ins carries a valid instruction.
REQ-007 Ins  in  32  MIPS instruction word.
REQ-008 Stall  in  1  downstream hold; pipeline register keeps its contents.
REQ-009 Flush  in  1  kill the instruction being captured.
REQ-010 WEn  in  1  write-back enable.
REQ-011 Wadr  in  AW  write-back register address.
REQ-012 Wdata  in  XLEN  write-back data.
REQ-013 OutValid  out  1  pipeline register holds a valid instruction.
REQ-014 Rdata1, Rdata2  out  XLEN  operands for rs (Ins[25:21]) and rt (Ins[20:16]), low AW bits used.
REQ-015 Ed  out  XLEN  extended immediate.
REQ-016 Opcode, Funct  out  6 each  registered Ins[31:26], Ins[5:0].
REQ-017 Dadr  out  AW  destination register; DWEn  out  1  destination write enable.

Function
REQ-018 Register file SHALL write Wdata to Wadr on every rising edge with WEn=1, independent of Stall, Flush, InValid; ZERO_REG=1 and Wadr=0 SHALL suppress the write.
REQ-019 Operand read SHALL bypass: if WEn=1 and Wadr equals source address (not 0 when ZERO_REG=1), the captured value SHALL be Wdata, else file contents.
REQ-020 Destination: Opcode 0x00 -> Ins[15:11]; 0x03 (JAL) -> NREG-1; otherwise Ins[20:16].
REQ-021 DWEn SHALL be 1 for Opcode 0x00 with Funct != 0x08, 0x03, 0x08-0x0F, 0x20-0x25; else 0; forced 0 when ZERO_REG=1 and Dadr=0, or InValid=0.
REQ-022 Ed: Opcode 0x0C-0x0E zero-extend Ins[15:0]; 0x0F (LUI) Ins[15:0] followed by 16 zeros, zero-extended to XLEN; otherwise sign-extend Ins[15:0] to XLEN.
REQ-023 Pipeline register update priority per edge: Flush=1 -> OutValid<=0, DWEn<=0, other outputs unchanged (Flush overrides Stall); else Stall=1 -> hold; else capture all decoded fields, OutValid<=InValid.
REQ-024 Latency: one cycle from Ins/InValid to outputs; no combinational path from inputs to outputs.
REQ-025 While holding (Stall=1, Flush=0, OutValid=1), a write with WEn=1 matching the held rs/rt address (stored internally) SHALL update the corresponding held Rdata1/Rdata2 on that edge; same rule for both when rs=rt.
REQ-026 Write and capture to the same register on the same edge SHALL yield the new value in both the file and the output (via REQ-019).

Reset
REQ-027 RST=1 SHALL immediately clear all registers of the file and all outputs to 0, including mid-stall; no write or capture occurs while RST=1.
REQ-028 First capture SHALL occur on the first rising edge with RST=0.

Verification
REQ-029 Write r5=0x1234 (WEn), next cycle Ins=ADD r3,r5,r5 valid -> Rdata1=Rdata2=0x1234, Dadr=3, DWEn=1, OutValid=1 one cycle later.
REQ-030 Same edge WEn r7=0xCAFE and Ins reading rs=7 -> Rdata1=0xCAFE; write to r0=0xFFFF then read r0 -> 0.
REQ-031 Ins ADDI imm 0x8000 -> Ed=0xFFFF8000; ORI imm 0x8000 -> Ed=0x00008000; LUI imm 0x1234 -> Ed=0x12340000; JAL -> Dadr=31, DWEn=1; JR -> DWEn=0.
REQ-032 Hold instruction reading r9 with Stall=1, write r9=0x55 during stall -> Rdata held value becomes 0x55; release Stall -> next instruction captured.
REQ-033 Flush with Stall=1 -> OutValid=0, DWEn=0 next edge; RST asserted asynchronously mid-stall -> all outputs and r1..r31 read 0 immediately.
